mpu_nx_region_cfg: RTL and testbench
====================================

// Module: mpu_nx_region_cfg
// PURPOSE
//   Programmable no-execute (NX) region unit. It is the configuration-writer and
//   registered-checker counterpart of the fixed execute-permission model.
//   Software writes NREG base/end/control register sets over a simple request/grant
//   bus. The fetch path issues address checks with a valid/ready handshake and
//   receives registered exec-allow responses. The first denied fetch address is
//   captured for the trap handler.
// PARAMETERS
//   NREG      4              number of NX regions (1..15)
//   NX_BASE   32'h2000_0000  reset value of region 0 BASE
//   NX_END    32'h2FFF_FFFF  reset value of region 0 END
// PORTS
//   clk_i              in   1   clock, all state updates on rising edge
//   rst_i              in   1   synchronous reset, active-high
//   cfg_req_i          in   1   config access request
//   cfg_we_i           in   1   1 = write, 0 = read
//   cfg_addr_i         in   6   register index (map below)
//   cfg_wdata_i        in   32  write data
//   cfg_gnt_o          out  1   grant; equals cfg_req_i (combinational, never stalls)
//   cfg_rvalid_o       out  1   response valid, exactly 1 cycle after each grant
//   cfg_rdata_o        out  32  read data (0 for writes and on error)
//   cfg_err_o          out  1   access error, valid with cfg_rvalid_o
//   chk_valid_i        in   1   check request valid
//   chk_paddr_i        in   32  physical fetch address to check
//   chk_ready_o        out  1   check request accepted when valid & ready
//   chk_rsp_valid_o    out  1   check response valid
//   chk_rsp_ready_i    in   1   consumer accepts response
//   chk_exec_allow_o   out  1   1 = execute allowed, valid with chk_rsp_valid_o
//   fault_o            out  1   level: FAULT_STATUS.valid
// BEHAVIOUR
// - Register map: idx 3r+0 BASE[r], 3r+1 END[r], 3r+2 CTRL[r] {bit1 lock, bit0 en} for r < NREG.
//   idx 62 FAULT_STATUS {bit1 overflow, bit0 valid}. Any write clears both bits.
//   idx 63 FAULT_ADDR (read-only; a write sets err and has no effect).
//   Any other idx: err=1, rdata=0, no state change.
// - Reset values: region 0 BASE=NX_BASE, END=NX_END, CTRL=2'b01.
//   All other regions are 0 with en=0. Fault regs = 0.
//   Outputs: cfg_rvalid_o=0, cfg_rdata_o=0, cfg_err_o=0, chk_rsp_valid_o=0,
//   chk_exec_allow_o=1, fault_o=0.
// - Config: a write commits at the edge ending the grant cycle.
//   Read data reflects state before any same-cycle update.
//   Writes to BASE/END/CTRL of a region with lock=1 are ignored and set err=1.
//   lock is set by a CTRL write and cleared only by reset.
//   A CTRL write with lock=1 also applies en from the same write.
// - Region match: en && BASE <= addr && addr <= END (unsigned, inclusive).
//   BASE > END never matches. Any match gives allow=0; no match gives allow=1.
// - Check pipeline: one output register.
//   chk_ready_o = !chk_rsp_valid_o | chk_rsp_ready_i.
//   On accept, the response appears on the next cycle (latency 1). It uses region
//   state as of the accept cycle, so a config write in that same cycle is not seen.
//   A response holds stable while valid & !ready. Back-to-back accepts give 1 response/cycle.
// - Fault capture occurs on the accept cycle of a denied check:
//   if valid=0, FAULT_ADDR <= paddr and valid <= 1; else overflow <= 1, FAULT_ADDR unchanged.
//   Capture and a FAULT_STATUS write in the same cycle: the capture wins and is
//   recorded as the first fault (valid=1, overflow=0, FAULT_ADDR=paddr).
// - Reset asserted mid-operation discards the pending response and any in-flight config
//   response. All state returns to reset values on the next edge.
// TESTING
// 1) Reset, then check 0x2000_0000 and 0x1FFF_FFFC -> allow=0 then allow=1, each 1 cycle
//    after accept; fault_o=1, FAULT_ADDR=0x2000_0000.
// 2) Program region 1 as BASE=0x8000_0000, END=0x8000_0FFF, CTRL=1.
//    Check 0x8000_0FFF -> 0, 0x8000_1000 -> 1, 0x7FFF_FFFF -> 1.
// 3) Write CTRL[1]=3, then write BASE[1]=0 -> err=1, BASE[1] readback unchanged.
//    Reset -> lock=0, en=0.
// 4) Two denied checks 0x2000_0010, then 0x2000_0020 -> FAULT_ADDR=0x2000_0010, overflow=1.
//    Write idx 62 -> status 0. Denied accept in the same cycle as that write -> valid=1, overflow=0.
// 5) Hold chk_rsp_ready_i=0 for 3 cycles with chk_valid_i=1 -> chk_ready_o=0 after the
//    first accept. Response stable, no dropped or duplicated responses.
// 6) Write idx 40 and idx 63 -> err=1, rdata=0, no state change.
//    Assert reset with a response pending -> chk_rsp_valid_o=0 on the next cycle.

Source files
------------

// File: rtl/mpu_nx_region_cfg.sv
// Programmable no-execute region unit.
// Software programs NREG base/end/control sets over a request/grant config bus.
// The fetch path checks addresses through a one-deep registered response stage.
// The first denied fetch address is captured for the trap handler.
module mpu_nx_region_cfg #(
    parameter int          NREG    = 4,
    parameter logic [31:0] NX_BASE = 32'h2000_0000,
    parameter logic [31:0] NX_END  = 32'h2FFF_FFFF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cfg_req_i,
    input  logic        cfg_we_i,
    input  logic [5:0]  cfg_addr_i,
    input  logic [31:0] cfg_wdata_i,
    output logic        cfg_gnt_o,
    output logic        cfg_rvalid_o,
    output logic [31:0] cfg_rdata_o,
    output logic        cfg_err_o,
    input  logic        chk_valid_i,
    input  logic [31:0] chk_paddr_i,
    output logic        chk_ready_o,
    output logic        chk_rsp_valid_o,
    input  logic        chk_rsp_ready_i,
    output logic        chk_exec_allow_o,
    output logic        fault_o
);

    localparam logic [5:0] IDX_FSTAT = 6'd62;
    localparam logic [5:0] IDX_FADDR = 6'd63;

    // Region state
    logic [31:0]     base_q [NREG];
    logic [31:0]     end_q  [NREG];
    logic [NREG-1:0] en_q;
    logic [NREG-1:0] lock_q;

    // Fault capture state
    logic            fault_valid_q;
    logic            fault_ovf_q;
    logic [31:0]     fault_addr_q;

    // Registered config response and check response
    logic            cfg_rvalid_q;
    logic            cfg_err_q;
    logic [31:0]     cfg_rdata_q;
    logic            rsp_valid_q;
    logic            allow_q;

    // Decode results
    logic [31:0]     rd_data;
    logic            acc_err;
    logic [NREG-1:0] wr_base;
    logic [NREG-1:0] wr_end;
    logic [NREG-1:0] wr_ctrl;
    logic            wr_fstat;
    logic            region_hit;
    logic            chk_accept;
    logic            deny_accept;

    assign cfg_gnt_o        = cfg_req_i;
    assign cfg_rvalid_o     = cfg_rvalid_q;
    assign cfg_rdata_o      = cfg_rdata_q;
    assign cfg_err_o        = cfg_err_q;
    assign chk_ready_o      = !rsp_valid_q || chk_rsp_ready_i;
    assign chk_rsp_valid_o  = rsp_valid_q;
    assign chk_exec_allow_o = allow_q;
    assign fault_o          = fault_valid_q;

    assign chk_accept  = chk_valid_i && chk_ready_o;
    assign deny_accept = chk_accept && region_hit;

    // Decode config index into read data, error flag and per-register write enables
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        rd_data  = '0;
        acc_err  = 1'b1;
        wr_base  = '0;
        wr_end   = '0;
        wr_ctrl  = '0;
        wr_fstat = 1'b0;
        if (cfg_addr_i == IDX_FSTAT) begin
            acc_err  = 1'b0;
            rd_data  = {30'b0, fault_ovf_q, fault_valid_q};
            wr_fstat = cfg_req_i && cfg_we_i;
        end else if (cfg_addr_i == IDX_FADDR) begin
            acc_err = cfg_we_i;
            rd_data = fault_addr_q;
        end
        for (int r = 0; r < NREG; r++) begin
            if (cfg_addr_i == 6'(3 * r)) begin
                acc_err    = cfg_we_i && lock_q[r];
                rd_data    = base_q[r];
                wr_base[r] = cfg_req_i && cfg_we_i && !lock_q[r];
            end else if (cfg_addr_i == 6'(3 * r + 1)) begin
                acc_err   = cfg_we_i && lock_q[r];
                rd_data   = end_q[r];
                wr_end[r] = cfg_req_i && cfg_we_i && !lock_q[r];
            end else if (cfg_addr_i == 6'(3 * r + 2)) begin
                acc_err    = cfg_we_i && lock_q[r];
                rd_data    = {30'b0, lock_q[r], en_q[r]};
                wr_ctrl[r] = cfg_req_i && cfg_we_i && !lock_q[r];
            end
        end
    end

    // Any enabled region containing the address denies execution
    always_comb begin
        region_hit = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            if (en_q[r] && (chk_paddr_i >= base_q[r]) && (chk_paddr_i <= end_q[r]))
                region_hit = 1'b1;
        end
    end

    // Region registers: commit unlocked writes at the end of the grant cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: the region file is a handful of flops, not a RAM, so every entry is reset.
            for (int r = 0; r < NREG; r++) begin
                base_q[r] <= (r == 0) ? NX_BASE : 32'h0;
                end_q[r]  <= (r == 0) ? NX_END  : 32'h0;
            end
            en_q   <= NREG'(1);
            lock_q <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                // NOTE: sequential state uses non-blocking assignments so all flops update together.
                if (wr_base[r]) base_q[r] <= cfg_wdata_i;
                if (wr_end[r])  end_q[r]  <= cfg_wdata_i;
                if (wr_ctrl[r]) begin
                    en_q[r]   <= cfg_wdata_i[0];
                    lock_q[r] <= cfg_wdata_i[1];
                end
            end
        end
    end

    // Fault capture: first denied accept records the address, later ones set overflow
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fault_valid_q <= 1'b0;
            fault_ovf_q   <= 1'b0;
            fault_addr_q  <= '0;
        end else if (deny_accept) begin
            // A simultaneous status clear makes this capture the first fault.
            if (!fault_valid_q || wr_fstat) begin
                fault_valid_q <= 1'b1;
                fault_ovf_q   <= 1'b0;
                fault_addr_q  <= chk_paddr_i;
            end else begin
                fault_ovf_q <= 1'b1;
            end
        end else if (wr_fstat) begin
            fault_valid_q <= 1'b0;
            fault_ovf_q   <= 1'b0;
        end
    end

    // Config response: one cycle after each grant, data only for error-free reads
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cfg_rvalid_q <= 1'b0;
            cfg_err_q    <= 1'b0;
            cfg_rdata_q  <= '0;
        end else begin
            cfg_rvalid_q <= cfg_req_i;
            cfg_err_q    <= cfg_req_i && acc_err;
            cfg_rdata_q  <= (cfg_req_i && !cfg_we_i && !acc_err) ? rd_data : 32'h0;
        end
    end

    // Check response register: load on accept, drain when the consumer takes it
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_valid_q <= 1'b0;
            allow_q     <= 1'b1;
        end else if (chk_accept) begin
            rsp_valid_q <= 1'b1;
            allow_q     <= !region_hit;
        end else if (chk_rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mpu_nx_region_cfg.sv
// Directed self-checking bench for mpu_nx_region_cfg.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mpu_nx_region_cfg;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        cfg_req_i = 1'b0;
    logic        cfg_we_i = 1'b0;
    logic [5:0]  cfg_addr_i = '0;
    logic [31:0] cfg_wdata_i = '0;
    logic        cfg_gnt_o;
    logic        cfg_rvalid_o;
    logic [31:0] cfg_rdata_o;
    logic        cfg_err_o;
    logic        chk_valid_i = 1'b0;
    logic [31:0] chk_paddr_i = '0;
    logic        chk_ready_o;
    logic        chk_rsp_valid_o;
    logic        chk_rsp_ready_i = 1'b1;
    logic        chk_exec_allow_o;
    logic        fault_o;

    int n_checks = 0;
    int n_fail   = 0;

    mpu_nx_region_cfg dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .cfg_req_i        (cfg_req_i),
        .cfg_we_i         (cfg_we_i),
        .cfg_addr_i       (cfg_addr_i),
        .cfg_wdata_i      (cfg_wdata_i),
        .cfg_gnt_o        (cfg_gnt_o),
        .cfg_rvalid_o     (cfg_rvalid_o),
        .cfg_rdata_o      (cfg_rdata_o),
        .cfg_err_o        (cfg_err_o),
        .chk_valid_i      (chk_valid_i),
        .chk_paddr_i      (chk_paddr_i),
        .chk_ready_o      (chk_ready_o),
        .chk_rsp_valid_o  (chk_rsp_valid_o),
        .chk_rsp_ready_i  (chk_rsp_ready_i),
        .chk_exec_allow_o (chk_exec_allow_o),
        .fault_o          (fault_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One config access; response checked on the following falling edge.
    task automatic cfg_xfer(input string tag, input logic we, input logic [5:0] addr,
                            input logic [31:0] wdata, input logic [31:0] exp_rdata,
                            input logic exp_err);
        @(negedge clk_i);
        cfg_req_i   = 1'b1;
        cfg_we_i    = we;
        cfg_addr_i  = addr;
        cfg_wdata_i = wdata;
        #1 check({tag, ".gnt"}, 32'(cfg_gnt_o), 32'd1);
        @(negedge clk_i);
        check({tag, ".rvalid"}, 32'(cfg_rvalid_o), 32'd1);
        check({tag, ".rdata"}, cfg_rdata_o, exp_rdata);
        check({tag, ".err"}, 32'(cfg_err_o), 32'(exp_err));
        cfg_req_i = 1'b0;
        cfg_we_i  = 1'b0;
    endtask

    // One check with the consumer always ready; response expected one cycle later.
    task automatic chk_one(input string tag, input logic [31:0] addr, input logic exp_allow);
        @(negedge clk_i);
        chk_valid_i     = 1'b1;
        chk_paddr_i     = addr;
        chk_rsp_ready_i = 1'b1;
        #1 check({tag, ".ready"}, 32'(chk_ready_o), 32'd1);
        @(negedge clk_i);
        check({tag, ".rsp_valid"}, 32'(chk_rsp_valid_o), 32'd1);
        check({tag, ".allow"}, 32'(chk_exec_allow_o), 32'(exp_allow));
        chk_valid_i = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    initial begin
        // 1) Reset values, region 0 default deny window and first-fault capture
        do_reset();
        check("rst.rvalid", 32'(cfg_rvalid_o), 32'd0);
        check("rst.rdata", cfg_rdata_o, 32'd0);
        check("rst.err", 32'(cfg_err_o), 32'd0);
        check("rst.rsp_valid", 32'(chk_rsp_valid_o), 32'd0);
        check("rst.allow", 32'(chk_exec_allow_o), 32'd1);
        check("rst.fault", 32'(fault_o), 32'd0);
        chk_one("t1.lo_edge", 32'h2000_0000, 1'b0);
        chk_one("t1.below", 32'h1FFF_FFFC, 1'b1);
        @(negedge clk_i);
        check("t1.rsp_drained", 32'(chk_rsp_valid_o), 32'd0);
        check("t1.fault", 32'(fault_o), 32'd1);
        cfg_xfer("t1.faddr", 1'b0, 6'd63, 32'h0, 32'h2000_0000, 1'b0);
        cfg_xfer("t1.fstat", 1'b0, 6'd62, 32'h0, 32'h0000_0001, 1'b0);
        cfg_xfer("t1.ctrl0", 1'b0, 6'd2, 32'h0, 32'h0000_0001, 1'b0);

        // 2) Program region 1, test inclusive end, and an inverted region 2
        cfg_xfer("t2.wbase1", 1'b1, 6'd3, 32'h8000_0000, 32'h0, 1'b0);
        cfg_xfer("t2.wend1", 1'b1, 6'd4, 32'h8000_0FFF, 32'h0, 1'b0);
        cfg_xfer("t2.wctrl1", 1'b1, 6'd5, 32'h0000_0001, 32'h0, 1'b0);
        chk_one("t2.end_edge", 32'h8000_0FFF, 1'b0);
        chk_one("t2.past_end", 32'h8000_1000, 1'b1);
        chk_one("t2.before", 32'h7FFF_FFFF, 1'b1);
        cfg_xfer("t2.rbase1", 1'b0, 6'd3, 32'h0, 32'h8000_0000, 1'b0);
        cfg_xfer("t2.wbase2", 1'b1, 6'd6, 32'h9000_0000, 32'h0, 1'b0);
        cfg_xfer("t2.wend2", 1'b1, 6'd7, 32'h8000_0000, 32'h0, 1'b0);
        cfg_xfer("t2.wctrl2", 1'b1, 6'd8, 32'h0000_0001, 32'h0, 1'b0);
        chk_one("t2.inverted", 32'h8800_0000, 1'b1);
        // Disable region 0 in the same cycle a check is accepted: the check sees old state.
        @(negedge clk_i);
        cfg_req_i   = 1'b1;
        cfg_we_i    = 1'b1;
        cfg_addr_i  = 6'd2;
        cfg_wdata_i = 32'h0;
        chk_valid_i = 1'b1;
        chk_paddr_i = 32'h2000_0040;
        @(negedge clk_i);
        check("t2.same_cyc.allow", 32'(chk_exec_allow_o), 32'd0);
        check("t2.same_cyc.err", 32'(cfg_err_o), 32'd0);
        cfg_req_i   = 1'b0;
        cfg_we_i    = 1'b0;
        chk_valid_i = 1'b0;
        chk_one("t2.after_dis", 32'h2000_0040, 1'b1);
        cfg_xfer("t2.rctrl0", 1'b0, 6'd2, 32'h0, 32'h0, 1'b0);

        // 3) Lock region 1, rejected writes, reset clears lock
        cfg_xfer("t3.lock", 1'b1, 6'd5, 32'h0000_0003, 32'h0, 1'b0);
        cfg_xfer("t3.wbase_locked", 1'b1, 6'd3, 32'h0, 32'h0, 1'b1);
        cfg_xfer("t3.rbase", 1'b0, 6'd3, 32'h0, 32'h8000_0000, 1'b0);
        cfg_xfer("t3.wctrl_locked", 1'b1, 6'd5, 32'h0, 32'h0, 1'b1);
        cfg_xfer("t3.rctrl", 1'b0, 6'd5, 32'h0, 32'h0000_0003, 1'b0);
        do_reset();
        cfg_xfer("t3.rctrl_rst", 1'b0, 6'd5, 32'h0, 32'h0, 1'b0);
        cfg_xfer("t3.rbase_rst", 1'b0, 6'd3, 32'h0, 32'h0, 1'b0);
        cfg_xfer("t3.rctrl0_rst", 1'b0, 6'd2, 32'h0, 32'h0000_0001, 1'b0);

        // 4) Overflow, status clear, capture racing a status clear
        chk_one("t4.deny1", 32'h2000_0010, 1'b0);
        chk_one("t4.deny2", 32'h2000_0020, 1'b0);
        cfg_xfer("t4.faddr", 1'b0, 6'd63, 32'h0, 32'h2000_0010, 1'b0);
        cfg_xfer("t4.fstat", 1'b0, 6'd62, 32'h0, 32'h0000_0003, 1'b0);
        cfg_xfer("t4.clear", 1'b1, 6'd62, 32'h0, 32'h0, 1'b0);
        cfg_xfer("t4.fstat_clr", 1'b0, 6'd62, 32'h0, 32'h0, 1'b0);
        check("t4.fault_clr", 32'(fault_o), 32'd0);
        chk_one("t4.deny3", 32'h2000_0050, 1'b0);
        chk_one("t4.deny4", 32'h2000_0060, 1'b0);
        @(negedge clk_i);
        cfg_req_i   = 1'b1;
        cfg_we_i    = 1'b1;
        cfg_addr_i  = 6'd62;
        cfg_wdata_i = 32'h0;
        chk_valid_i = 1'b1;
        chk_paddr_i = 32'h2000_0030;
        @(negedge clk_i);
        cfg_req_i   = 1'b0;
        cfg_we_i    = 1'b0;
        chk_valid_i = 1'b0;
        cfg_xfer("t4.race_fstat", 1'b0, 6'd62, 32'h0, 32'h0000_0001, 1'b0);
        cfg_xfer("t4.race_faddr", 1'b0, 6'd63, 32'h0, 32'h2000_0030, 1'b0);

        // 5) Backpressure: response held stable, next request waits, no loss or duplicate
        @(negedge clk_i);
        chk_rsp_ready_i = 1'b0;
        chk_valid_i     = 1'b1;
        chk_paddr_i     = 32'h2000_0100;
        #1 check("t5.ready0", 32'(chk_ready_o), 32'd1);
        @(negedge clk_i);
        chk_paddr_i = 32'h1000_0000;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t5.hold.ready", 32'(chk_ready_o), 32'd0);
            check("t5.hold.valid", 32'(chk_rsp_valid_o), 32'd1);
            check("t5.hold.allow", 32'(chk_exec_allow_o), 32'd0);
            @(negedge clk_i);
        end
        chk_rsp_ready_i = 1'b1;
        #1 check("t5.release.ready", 32'(chk_ready_o), 32'd1);
        @(negedge clk_i);
        chk_valid_i = 1'b0;
        check("t5.second.valid", 32'(chk_rsp_valid_o), 32'd1);
        check("t5.second.allow", 32'(chk_exec_allow_o), 32'd1);
        @(negedge clk_i);
        check("t5.drained", 32'(chk_rsp_valid_o), 32'd0);

        // 6) Bad indices, read-only FAULT_ADDR, reset with responses in flight
        cfg_xfer("t6.w40", 1'b1, 6'd40, 32'hFFFF_FFFF, 32'h0, 1'b1);
        cfg_xfer("t6.r40", 1'b0, 6'd40, 32'h0, 32'h0, 1'b1);
        cfg_xfer("t6.w63", 1'b1, 6'd63, 32'hDEAD_BEEF, 32'h0, 1'b1);
        cfg_xfer("t6.r63", 1'b0, 6'd63, 32'h0, 32'h2000_0030, 1'b0);
        cfg_xfer("t6.rctrl0", 1'b0, 6'd2, 32'h0, 32'h0000_0001, 1'b0);
        @(negedge clk_i);
        chk_rsp_ready_i = 1'b0;
        chk_valid_i     = 1'b1;
        chk_paddr_i     = 32'h2000_0200;
        cfg_req_i       = 1'b1;
        cfg_addr_i      = 6'd0;
        @(negedge clk_i);
        check("t6.pending", 32'(chk_rsp_valid_o), 32'd1);
        check("t6.cfg_pending", 32'(cfg_rvalid_o), 32'd1);
        rst_i       = 1'b1;
        chk_valid_i = 1'b0;
        @(negedge clk_i);
        check("t6.rst.rsp_valid", 32'(chk_rsp_valid_o), 32'd0);
        check("t6.rst.rvalid", 32'(cfg_rvalid_o), 32'd0);
        check("t6.rst.allow", 32'(chk_exec_allow_o), 32'd1);
        check("t6.rst.fault", 32'(fault_o), 32'd0);
        cfg_req_i       = 1'b0;
        chk_rsp_ready_i = 1'b1;
        rst_i           = 1'b0;
        cfg_xfer("t6.rbase0", 1'b0, 6'd0, 32'h0, 32'h2000_0000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
